// File: rtl/uart_baudgen_frac_pkg.sv
// rtl/uart_baudgen_frac_pkg.sv - shared widths and config record for the UART baud tick generator
package uart_baudgen_frac_pkg;

    localparam int BaudDivW       = 16;
    localparam int BaudFracW      = 4;
    localparam int BaudOversample = 16;

    typedef struct packed {
        logic [BaudDivW-1:0]  divisor;
        logic [BaudFracW-1:0] frac;
    } baud_cfg_t;

endpackage

// File: rtl/uart_baudgen_frac_if.sv
// rtl/uart_baudgen_frac_if.sv - divisor config, resync request and tick outputs of the baud generator
interface uart_baudgen_frac_if #(
    parameter int DIV_W  = uart_baudgen_frac_pkg::BaudDivW,
    parameter int FRAC_W = uart_baudgen_frac_pkg::BaudFracW
) ();

    logic [DIV_W-1:0]  divisor_i;
    logic [FRAC_W-1:0] frac_i;
    logic              cfg_write_i;
    logic              resync_i;
    logic              oversample_edge_o;
    logic              half_edge_o;
    logic              baud_edge_o;
    logic              active_o;

    modport master (
        output divisor_i, frac_i, cfg_write_i, resync_i,
        input  oversample_edge_o, half_edge_o, baud_edge_o, active_o
    );

    modport slave (
        input  divisor_i, frac_i, cfg_write_i, resync_i,
        output oversample_edge_o, half_edge_o, baud_edge_o, active_o
    );

endinterface

// File: rtl/uart_baudgen_frac_counter.sv
// rtl/uart_baudgen_frac_counter.sv - wrapping up-counter with clear, load and enable (clear > load > en)
module uart_baudgen_frac_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = d_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/uart_baudgen_frac.sv
// rtl/uart_baudgen_frac.sv - oversample/half-bit/bit tick generator; fractional divisor enabled by UART_BAUD_FRAC_EN
module uart_baudgen_frac
    import uart_baudgen_frac_pkg::*;
#(
    parameter int DIV_W      = BaudDivW,
    parameter int FRAC_W     = BaudFracW,
    parameter int OVERSAMPLE = BaudOversample
) (
    input logic                clk_i,
    input logic                rst_ni,
    uart_baudgen_frac_if.slave bus
);

    localparam int               SubW    = $clog2(OVERSAMPLE);
    localparam logic [SubW-1:0]  SubLast = SubW'(OVERSAMPLE - 1);
    localparam logic [SubW-1:0]  SubHalf = SubW'(OVERSAMPLE / 2 - 1);
    localparam logic [SubW-1:0]  SubMid  = SubW'(OVERSAMPLE / 2);

    logic             valid;
    logic             wrap;
    logic             resync_ok;
    logic             emit;
    logic             stretch_q;
    logic [DIV_W:0]   term;
    logic [DIV_W:0]   os_cnt_q, os_cnt_d;
    logic [SubW-1:0]  sub_cnt;
    logic             os_edge_q, os_edge_d;
    logic             half_edge_q, half_edge_d;
    logic             baud_edge_q, baud_edge_d;

    assign valid     = |bus.divisor_i;
    assign term      = {1'b0, bus.divisor_i} - {{DIV_W{1'b0}}, 1'b1} + {{DIV_W{1'b0}}, stretch_q};
    // >= rather than == so a divisor shrunk below the running count wraps at once
    assign wrap      = valid && (os_cnt_q >= term);
    assign resync_ok = valid && bus.resync_i && !bus.cfg_write_i;
    assign emit      = wrap && !bus.cfg_write_i && !resync_ok;

    always_comb begin
        os_cnt_d = os_cnt_q + 1'b1;
        if (bus.cfg_write_i || !valid || wrap || resync_ok) begin
            os_cnt_d = '0;
        end
        os_edge_d   = emit;
        baud_edge_d = emit && (sub_cnt == SubLast);
        half_edge_d = emit && ((sub_cnt == SubLast) || (sub_cnt == SubHalf));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            os_cnt_q    <= '0;
            os_edge_q   <= 1'b0;
            half_edge_q <= 1'b0;
            baud_edge_q <= 1'b0;
        end else begin
            os_cnt_q    <= os_cnt_d;
            os_edge_q   <= os_edge_d;
            half_edge_q <= half_edge_d;
            baud_edge_q <= baud_edge_d;
        end
    end

    // Resync lands mid-bit so the next bit tick falls on the start-bit centre
    uart_baudgen_frac_counter #(
        .WIDTH (SubW),
        .MAX   (SubLast)
    ) u_sub_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (bus.cfg_write_i || !valid),
        .load_i  (resync_ok),
        .d_i     (SubMid),
        .en_i    (wrap),
        .q_o     (sub_cnt)
    );

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              stretch_d;

    always_comb begin
        acc_d     = acc_q;
        stretch_d = stretch_q;
        if (bus.cfg_write_i || !valid || resync_ok) begin
            acc_d     = '0;
            stretch_d = 1'b0;
        end else if (wrap) begin
            {stretch_d, acc_d} = {1'b0, acc_q} + {1'b0, bus.frac_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^bus.frac_i;
    assign stretch_q   = 1'b0;
`endif

    assign bus.oversample_edge_o = os_edge_q;
    assign bus.half_edge_o       = half_edge_q;
    assign bus.baud_edge_o       = baud_edge_q;
    assign bus.active_o          = valid;

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// tb/tb_uart_baudgen_frac.sv - self-checking bench for uart_baudgen_frac
module tb_uart_baudgen_frac;
    import uart_baudgen_frac_pkg::*;

    localparam int OS = 16;
`ifdef UART_BAUD_FRAC_EN
    localparam bit FRAC = 1'b1;
`else
    localparam bit FRAC = 1'b0;
`endif

    typedef struct {
        baud_cfg_t cfg;
        int        n;
        int        first_os;
        int        first_baud;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    bit    mon_en = 1'b0;
    int    first_os = -1;
    int    first_baud = -1;
    int    exp_q[3][$];
    string names[3];
    logic [2:0] pulses;
    vec_t  vecs[7];

    uart_baudgen_frac_if #(.DIV_W(BaudDivW), .FRAC_W(BaudFracW)) bus ();

    uart_baudgen_frac #(
        .DIV_W      (BaudDivW),
        .FRAC_W     (BaudFracW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pulses = {bus.baud_edge_o, bus.half_edge_o, bus.oversample_edge_o};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every observed pulse pops the expected cycle stamp of its kind
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (pulses[i]) begin
                    if (exp_q[i].size() == 0) check({names[i], " unexpected pulse at cycle"}, cyc, -1);
                    else check({names[i], " pulse cycle"}, cyc, exp_q[i].pop_front());
                    if (i == 0 && first_os < 0) first_os = cyc;
                    if (i == 2 && first_baud < 0) first_baud = cyc;
                end
            end
        end
    end

    function automatic vec_t mk(input int d, input int f, input int n, input int fo, input int fb);
        vec_t v;
        v.cfg.divisor = BaudDivW'(d);
        v.cfg.frac    = BaudFracW'(f);
        v.n           = n;
        v.first_os    = fo;
        v.first_baud  = fb;
        return v;
    endfunction

    task automatic push_edges(input int start, input int d, input int f, input int n, input int sub0);
        int t, acc, st, sub;
        t = start; acc = 0; st = 0; sub = sub0;
        for (int k = 0; k < n; k++) begin
            t += d + st;
            exp_q[0].push_back(t);
            if (sub == OS - 1 || sub == OS / 2 - 1) exp_q[1].push_back(t);
            if (sub == OS - 1) exp_q[2].push_back(t);
            sub = (sub == OS - 1) ? 0 : sub + 1;
            acc += f;
`ifdef UART_BAUD_FRAC_EN
            st  = acc >> BaudFracW;
            acc = acc % (1 << BaudFracW);
`else
            st = 0;
`endif
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20000 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0; i++) begin
            @(negedge clk); #2;
        end
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({names[i], " pulses outstanding"}, exp_q[i].size(), 0);
            exp_q[i].delete();
        end
    endtask

    task automatic apply(input int d, input int f, input bit cfg, input bit res);
        @(negedge clk); #1;
        bus.divisor_i   = BaudDivW'(d);
        bus.frac_i      = BaudFracW'(f);
        bus.cfg_write_i = cfg;
        bus.resync_i    = res;
    endtask

    task automatic settle(output int start);
        @(posedge clk); #1;
        start           = cyc;
        bus.cfg_write_i = 1'b0;
        bus.resync_i    = 1'b0;
        first_os        = -1;
        first_baud      = -1;
    endtask

    initial begin
        int s, start;
        names[0] = "oversample_edge";
        names[1] = "half_edge";
        names[2] = "baud_edge";
        vecs[0] = mk(4, 0, 40, 4, 64);
        vecs[1] = mk(3, 0, 20, 3, 48);
        vecs[2] = mk(1, 0, 40, 1, 16);
        vecs[3] = mk(7, 0, 20, 7, 112);
        vecs[4] = mk(4, 8, 36, 4, FRAC ? 71 : 64);
        vecs[5] = mk(5, 3, 34, 5, FRAC ? 82 : 80);
        vecs[6] = mk(2, 15, 32, 2, FRAC ? 46 : 32);

        bus.divisor_i = '0; bus.frac_i = '0; bus.cfg_write_i = 1'b0; bus.resync_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset oversample_edge", bus.oversample_edge_o, 0);
        check("reset half_edge", bus.half_edge_o, 0);
        check("reset baud_edge", bus.baud_edge_o, 0);
        check("reset active", bus.active_o, 0);
        #1 rst_n = 1'b1;

        // Disabled divisor: any pulse is reported as unexpected
        apply(0, 0, 0, 0);
        mon_en = 1'b1;
        repeat (200) @(negedge clk);
        #1 check("idle active", bus.active_o, 0);
        bus.divisor_i = 3; start = cyc; first_os = -1; first_baud = -1;
        push_edges(start, 3, 0, 20, 0);
        drain();
        check("enable first oversample offset", first_os - start, 3);
        check("enable first baud offset", first_baud - start, 48);

        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].cfg.divisor, vecs[i].cfg.frac, 1'b1, 1'b0);
            settle(start);
            check("vector active", bus.active_o, 1);
            push_edges(start, vecs[i].cfg.divisor, vecs[i].cfg.frac, vecs[i].n, 0);
            mon_en = 1'b1;
            drain();
            check("vector first oversample offset", first_os - start, vecs[i].first_os);
            check("vector first baud offset", first_baud - start, vecs[i].first_baud);
        end

        // Resync on a wrap cycle: pulse suppressed, bit tick at mid-bit distance
        apply(10, 0, 1'b1, 1'b0);
        settle(s);
        repeat (39) @(posedge clk);
        @(negedge clk); #1 bus.resync_i = 1'b1;
        settle(start);
        push_edges(start, 10, 0, 24, OS / 2);
        mon_en = 1'b1;
        drain();
        check("resync first baud offset", first_baud - start, 80);

        // Divisor shrinks below the running count
        apply(100, 0, 1'b1, 1'b0);
        settle(s);
        mon_en = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk); #1 bus.divisor_i = 10;
        push_edges(s + 41, 10, 0, 20, 0);
        drain();
        check("shrink first oversample offset", first_os - s, 51);

        // Same shrink together with cfg_write
        apply(100, 0, 1'b1, 1'b0);
        settle(s);
        mon_en = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk); #1 bus.divisor_i = 10; bus.cfg_write_i = 1'b1;
        settle(start);
        push_edges(start, 10, 0, 20, 0);
        drain();
        check("shrink+cfg first baud offset", first_baud - start, 160);

        // cfg_write beats resync
        apply(5, 0, 1'b1, 1'b0);
        settle(s);
        repeat (20) @(posedge clk);
        apply(5, 0, 1'b1, 1'b1);
        settle(start);
        push_edges(start, 5, 0, 20, 0);
        mon_en = 1'b1;
        drain();
        check("cfg+resync first baud offset", first_baud - start, 80);

        // Asynchronous reset mid-bit
        apply(1, 0, 1'b1, 1'b0);
        settle(s);
        repeat (3) @(negedge clk);
        check("pre-reset oversample_edge", bus.oversample_edge_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset oversample_edge", bus.oversample_edge_o, 0);
        check("async reset half_edge", bus.half_edge_o, 0);
        check("async reset baud_edge", bus.baud_edge_o, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        start = cyc; first_os = -1; first_baud = -1;
        push_edges(start, 1, 0, 20, 0);
        mon_en = 1'b1;
        drain();
        check("post-reset first baud offset", first_baud - start, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
